// File: rtl/mmu_tlb_pkg.sv
// Shared types for the TLB miss controller: entry layout and FSM state encoding.
// Entry field widths are the upper bound for the VPN_W/PPN_W/ASID_W module parameters.
package mmu_tlb_pkg;

  localparam int unsigned TLB_VPN_W  = 27;
  localparam int unsigned TLB_PPN_W  = 44;
  localparam int unsigned TLB_ASID_W = 16;

  typedef struct packed {
    logic                  valid;
    logic [TLB_VPN_W-1:0]  vpn;
    logic [TLB_ASID_W-1:0] asid;
    logic [TLB_PPN_W-1:0]  ppn;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WALK_REQ  = 2'd1,
    WALK_WAIT = 2'd2,
    FILL      = 2'd3
  } tlb_state_t;

endpackage

// File: rtl/tlb_cam_match.sv
// Fully associative tag compare over all TLB entries; multiple matches resolve to the lowest index.
module tlb_cam_match
  import mmu_tlb_pkg::*;
#(
  parameter  int unsigned ENTRIES = 8,
  localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0]    ent_valid,
  input  logic [TLB_VPN_W-1:0]  ent_vpn  [ENTRIES],
  input  logic [TLB_ASID_W-1:0] ent_asid [ENTRIES],
  input  logic [TLB_VPN_W-1:0]  vpn,
  input  logic [TLB_ASID_W-1:0] asid,
  output logic                  hit,
  output logic [IDX_W-1:0]      idx
);

  // Scan high to low so the last match written is the lowest index.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (ent_valid[IDX_W'(i)] && (ent_vpn[IDX_W'(i)] == vpn) && (ent_asid[IDX_W'(i)] == asid)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/tlb_miss_ctrl.sv
// TLB lookup with page-table-walk miss handling, victim fill and pseudoLRU hooks.
// Optional TLB_PERF_CNT_EN adds 32-bit hit/miss counters (hit_cnt_o, miss_cnt_o).
module tlb_miss_ctrl
  import mmu_tlb_pkg::*;
#(
  parameter  int unsigned ENTRIES = 8,
  parameter  int unsigned VPN_W   = 27,
  parameter  int unsigned PPN_W   = 44,
  parameter  int unsigned ASID_W  = 16,
  localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lu_valid_i,
  output logic              lu_ready_o,
  input  logic [VPN_W-1:0]  lu_vpn_i,
  input  logic [ASID_W-1:0] lu_asid_i,
  output logic              rsp_valid_o,
  output logic [PPN_W-1:0]  rsp_ppn_o,
  output logic              rsp_error_o,
  output logic              ptw_req_valid_o,
  input  logic              ptw_req_ready_i,
  output logic [VPN_W-1:0]  ptw_req_vpn_o,
  input  logic              ptw_resp_valid_i,
  input  logic [PPN_W-1:0]  ptw_resp_ppn_i,
  input  logic              ptw_resp_error_i,
  output logic              plru_hit_o,
  output logic [IDX_W-1:0]  plru_idx_o,
  input  logic [IDX_W-1:0]  plru_repl_idx_i,
  input  logic              flush_i
`ifdef TLB_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  tlb_state_t            state, state_n;
  tlb_entry_t            entries [ENTRIES];
  logic [VPN_W-1:0]      req_vpn;
  logic [ASID_W-1:0]     req_asid;
  logic                  lu_pend;
  logic [PPN_W-1:0]      fill_ppn;
  logic                  fill_err;
  logic                  fill_drop;
  logic                  do_fill;
  logic                  accept;
  logic [IDX_W-1:0]      victim;
  logic [ENTRIES-1:0]    ent_valid;
  logic [TLB_VPN_W-1:0]  ent_vpn  [ENTRIES];
  logic [TLB_ASID_W-1:0] ent_asid [ENTRIES];
  logic                  cam_hit;
  logic [IDX_W-1:0]      cam_idx;

  assign accept        = lu_valid_i && lu_ready_o;
  assign ptw_req_vpn_o = req_vpn;

  always_comb begin
    for (int i = 0; i < int'(ENTRIES); i++) begin
      ent_valid[IDX_W'(i)] = entries[IDX_W'(i)].valid;
      ent_vpn[IDX_W'(i)]   = entries[IDX_W'(i)].vpn;
      ent_asid[IDX_W'(i)]  = entries[IDX_W'(i)].asid;
    end
  end

  tlb_cam_match #(
    .ENTRIES (ENTRIES)
  ) u_cam (
    .ent_valid (ent_valid),
    .ent_vpn   (ent_vpn),
    .ent_asid  (ent_asid),
    .vpn       (TLB_VPN_W'(req_vpn)),
    .asid      (TLB_ASID_W'(req_asid)),
    .hit       (cam_hit),
    .idx       (cam_idx)
  );

  // Lowest invalid entry wins; the pseudoLRU choice applies only when the TLB is full.
  always_comb begin
    victim = plru_repl_idx_i;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (!entries[IDX_W'(i)].valid) victim = IDX_W'(i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  // Lookups are not accepted during the compare cycle so a response never overlaps an accept.
  always_comb begin
    state_n         = state;
    lu_ready_o      = 1'b0;
    rsp_valid_o     = 1'b0;
    rsp_ppn_o       = '0;
    rsp_error_o     = 1'b0;
    ptw_req_valid_o = 1'b0;
    plru_hit_o      = 1'b0;
    plru_idx_o      = '0;
    do_fill         = 1'b0;
    case (state)
      IDLE: begin
        lu_ready_o = !flush_i && !lu_pend;
        if (lu_pend) begin
          if (cam_hit) begin
            rsp_valid_o = 1'b1;
            rsp_ppn_o   = PPN_W'(entries[cam_idx].ppn);
            plru_hit_o  = 1'b1;
            plru_idx_o  = cam_idx;
          end else begin
            state_n = WALK_REQ;
          end
        end
      end
      WALK_REQ: begin
        ptw_req_valid_o = 1'b1;
        if (ptw_req_ready_i) state_n = WALK_WAIT;
      end
      WALK_WAIT: begin
        if (ptw_resp_valid_i) state_n = FILL;
      end
      FILL: begin
        rsp_valid_o = 1'b1;
        state_n     = IDLE;
        if (fill_err) begin
          rsp_error_o = 1'b1;
        end else begin
          rsp_ppn_o = fill_ppn;
          if (!fill_drop && !flush_i) begin
            do_fill    = 1'b1;
            plru_hit_o = 1'b1;
            plru_idx_o = victim;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A flush seen mid-walk marks the pending fill as stale so it is answered but not cached.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lu_pend   <= 1'b0;
      req_vpn   <= '0;
      req_asid  <= '0;
      fill_ppn  <= '0;
      fill_err  <= 1'b0;
      fill_drop <= 1'b0;
      for (int i = 0; i < int'(ENTRIES); i++) entries[IDX_W'(i)] <= '0;
    end else begin
      lu_pend <= accept;
      if (accept) begin
        req_vpn  <= lu_vpn_i;
        req_asid <= lu_asid_i;
      end
      if ((state == WALK_WAIT) && ptw_resp_valid_i) begin
        fill_ppn <= ptw_resp_ppn_i;
        fill_err <= ptw_resp_error_i;
      end
      if (state == IDLE)                 fill_drop <= 1'b0;
      else if (flush_i && state != FILL) fill_drop <= 1'b1;
      if (flush_i) begin
        for (int i = 0; i < int'(ENTRIES); i++) entries[IDX_W'(i)].valid <= 1'b0;
      end else if (do_fill) begin
        entries[victim] <= '{valid: 1'b1,
                             vpn:   TLB_VPN_W'(req_vpn),
                             asid:  TLB_ASID_W'(req_asid),
                             ppn:   TLB_PPN_W'(fill_ppn)};
      end
    end
  end

`ifdef TLB_PERF_CNT_EN
  logic hit_evt, miss_evt;
  assign hit_evt  = (state == IDLE) && lu_pend && cam_hit;
  assign miss_evt = (state == IDLE) && lu_pend && !cam_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit_evt)  hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (miss_evt) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tlb_miss_ctrl.sv
// Directed self-checking bench for tlb_miss_ctrl (counter checks when TLB_PERF_CNT_EN is defined).
module tb_tlb_miss_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        lu_valid;
  logic        lu_ready;
  logic [26:0] lu_vpn;
  logic [15:0] lu_asid;
  logic        rsp_valid;
  logic [43:0] rsp_ppn;
  logic        rsp_error;
  logic        ptw_req_valid;
  logic        ptw_req_ready;
  logic [26:0] ptw_req_vpn;
  logic        ptw_resp_valid;
  logic [43:0] ptw_resp_ppn;
  logic        ptw_resp_error;
  logic        plru_hit;
  logic [2:0]  plru_idx;
  logic [2:0]  plru_repl;
  logic        flush;
`ifdef TLB_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tlb_miss_ctrl dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .lu_valid_i       (lu_valid),
    .lu_ready_o       (lu_ready),
    .lu_vpn_i         (lu_vpn),
    .lu_asid_i        (lu_asid),
    .rsp_valid_o      (rsp_valid),
    .rsp_ppn_o        (rsp_ppn),
    .rsp_error_o      (rsp_error),
    .ptw_req_valid_o  (ptw_req_valid),
    .ptw_req_ready_i  (ptw_req_ready),
    .ptw_req_vpn_o    (ptw_req_vpn),
    .ptw_resp_valid_i (ptw_resp_valid),
    .ptw_resp_ppn_i   (ptw_resp_ppn),
    .ptw_resp_error_i (ptw_resp_error),
    .plru_hit_o       (plru_hit),
    .plru_idx_o       (plru_idx),
    .plru_repl_idx_i  (plru_repl),
    .flush_i          (flush)
`ifdef TLB_PERF_CNT_EN
    ,
    .hit_cnt_o        (hit_cnt),
    .miss_cnt_o       (miss_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Lookup expected to hit: response exactly one cycle after the accept.
  task automatic lookup_hit(input logic [26:0] vpn, input logic [15:0] asid,
                            input logic [43:0] ppn, input logic [2:0] idx, input string tag);
    lu_valid = 1'b1; lu_vpn = vpn; lu_asid = asid; #1;
    chk({tag, ":ready"}, 64'(lu_ready), 64'd1);
    cyc(); lu_valid = 1'b0; #1;
    chk({tag, ":rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, ":rsp_ppn"}, 64'(rsp_ppn), 64'(ppn));
    chk({tag, ":rsp_error"}, 64'(rsp_error), 64'd0);
    chk({tag, ":plru_hit"}, 64'(plru_hit), 64'd1);
    chk({tag, ":plru_idx"}, 64'(plru_idx), 64'(idx));
    chk({tag, ":no_ready_during_rsp"}, 64'(lu_ready), 64'd0);
    cyc(); #1;
    chk({tag, ":no_ptw"}, 64'(ptw_req_valid), 64'd0);
    chk({tag, ":rsp_one_cycle"}, 64'(rsp_valid), 64'd0);
  endtask

  // Lookup expected to miss, followed by a full walk and fill.
  task automatic lookup_miss(input logic [26:0] vpn, input logic [15:0] asid,
                             input logic [43:0] ppn, input logic err, input logic [2:0] victim,
                             input int delay, input logic flush_wait, input string tag);
    lu_valid = 1'b1; lu_vpn = vpn; lu_asid = asid; #1;
    chk({tag, ":ready"}, 64'(lu_ready), 64'd1);
    cyc(); lu_valid = 1'b0; #1;
    chk({tag, ":no_hit_rsp"}, 64'(rsp_valid), 64'd0);
    chk({tag, ":no_hit_plru"}, 64'(plru_hit), 64'd0);
    cyc(); #1;
    chk({tag, ":ptw_valid"}, 64'(ptw_req_valid), 64'd1);
    chk({tag, ":ptw_vpn"}, 64'(ptw_req_vpn), 64'(vpn));
    for (int d = 0; d < delay; d++) begin
      cyc(); #1;
      chk({tag, ":ptw_valid_hold"}, 64'(ptw_req_valid), 64'd1);
      chk({tag, ":ptw_vpn_hold"}, 64'(ptw_req_vpn), 64'(vpn));
    end
    ptw_req_ready = 1'b1;
    cyc(); ptw_req_ready = 1'b0; #1;
    chk({tag, ":ptw_valid_drop"}, 64'(ptw_req_valid), 64'd0);
    chk({tag, ":wait_no_rsp"}, 64'(rsp_valid), 64'd0);
    ptw_resp_valid = 1'b1; ptw_resp_ppn = ppn; ptw_resp_error = err; flush = flush_wait;
    cyc(); ptw_resp_valid = 1'b0; ptw_resp_ppn = '0; ptw_resp_error = 1'b0; flush = 1'b0; #1;
    chk({tag, ":fill_rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, ":fill_rsp_error"}, 64'(rsp_error), 64'(err));
    chk({tag, ":fill_rsp_ppn"}, 64'(rsp_ppn), err ? 64'd0 : 64'(ppn));
    chk({tag, ":fill_plru_hit"}, 64'(plru_hit), 64'(!err && !flush_wait));
    if (!err && !flush_wait) chk({tag, ":fill_plru_idx"}, 64'(plru_idx), 64'(victim));
    cyc(); #1;
    chk({tag, ":back_idle_ready"}, 64'(lu_ready), 64'd1);
    chk({tag, ":rsp_one_cycle"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; lu_valid = 1'b0; lu_vpn = '0; lu_asid = '0; ptw_req_ready = 1'b0;
    ptw_resp_valid = 1'b0; ptw_resp_ppn = '0; ptw_resp_error = 1'b0; plru_repl = 3'd3; flush = 1'b0;
    repeat (3) cyc();
    rst = 1'b0; #1;
    chk("reset:lu_ready", 64'(lu_ready), 64'd1);
    chk("reset:rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset:rsp_error", 64'(rsp_error), 64'd0);
    chk("reset:rsp_ppn", 64'(rsp_ppn), 64'd0);
    chk("reset:ptw_req_valid", 64'(ptw_req_valid), 64'd0);
    chk("reset:plru_hit", 64'(plru_hit), 64'd0);
    chk("reset:plru_idx", 64'(plru_idx), 64'd0);
    cyc();

    // First miss fills entry 0; then hit, and a different ASID misses into entry 1.
    lookup_miss(27'h10, 16'd1, 44'h55, 1'b0, 3'd0, 0, 1'b0, "miss_first");
    lookup_hit(27'h10, 16'd1, 44'h55, 3'd0, "hit_first");
    lookup_miss(27'h10, 16'd2, 44'h66, 1'b0, 3'd1, 0, 1'b0, "miss_asid2");

    // Fill entries 2..7 while pseudoLRU points elsewhere: lowest invalid must win.
    for (int i = 0; i < 6; i++)
      lookup_miss(27'h20 + 27'(i), 16'd1, 44'h100 + 44'(i), 1'b0, 3'(i + 2), 0, 1'b0, "fill_rest");

    // Full TLB: victim comes from pseudoLRU.
    plru_repl = 3'd5;
    lookup_miss(27'h30, 16'd1, 44'h99, 1'b0, 3'd5, 0, 1'b0, "repl_plru");
    lookup_hit(27'h30, 16'd1, 44'h99, 3'd5, "hit_repl");
    lookup_hit(27'h22, 16'd1, 44'h102, 3'd4, "hit_e4");
    lookup_hit(27'h24, 16'd1, 44'h104, 3'd6, "hit_e6");
    lookup_hit(27'h10, 16'd2, 44'h66, 3'd1, "hit_e1");
    lookup_hit(27'h10, 16'd1, 44'h55, 3'd0, "hit_e0");

    // Evicted VPN misses; slow PTW handshake; error response writes nothing.
    lookup_miss(27'h23, 16'd1, 44'h77, 1'b1, 3'd0, 4, 1'b0, "err_slow");
    lookup_miss(27'h23, 16'd1, 44'h78, 1'b1, 3'd0, 0, 1'b0, "err_not_written");

    // Flush during WALK_WAIT: response returned, TLB empty afterwards.
    lookup_miss(27'h40, 16'd1, 44'h44, 1'b0, 3'd0, 0, 1'b1, "flush_wait");
    lookup_miss(27'h10, 16'd1, 44'h55, 1'b0, 3'd0, 0, 1'b0, "after_flush_miss");
    lookup_miss(27'h40, 16'd1, 44'h44, 1'b0, 3'd1, 0, 1'b0, "flushed_vpn_miss");

    // Flush in IDLE blocks the accept and empties the TLB.
    lu_valid = 1'b1; lu_vpn = 27'h40; lu_asid = 16'd1; flush = 1'b1; #1;
    chk("flush_idle:ready_low", 64'(lu_ready), 64'd0);
    cyc(); lu_valid = 1'b0; flush = 1'b0; #1;
    chk("flush_idle:no_rsp", 64'(rsp_valid), 64'd0);
    cyc(); #1;
    chk("flush_idle:no_walk", 64'(ptw_req_valid), 64'd0);
    lookup_miss(27'h40, 16'd1, 44'h44, 1'b0, 3'd0, 0, 1'b0, "flush_idle_miss");

    // Reset mid-walk drops it; a late PTW response in IDLE is ignored.
    lu_valid = 1'b1; lu_vpn = 27'h50; lu_asid = 16'd1;
    cyc(); lu_valid = 1'b0;
    cyc(); #1;
    chk("rst_walk:in_walk", 64'(ptw_req_valid), 64'd1);
    rst = 1'b1;
    cyc(); rst = 1'b0; #1;
    chk("rst_walk:ready", 64'(lu_ready), 64'd1);
    chk("rst_walk:ptw_dropped", 64'(ptw_req_valid), 64'd0);
    ptw_resp_valid = 1'b1; ptw_resp_ppn = 44'h123;
    cyc(); ptw_resp_valid = 1'b0; ptw_resp_ppn = '0; #1;
    chk("late_resp:no_rsp", 64'(rsp_valid), 64'd0);
    chk("late_resp:ready", 64'(lu_ready), 64'd1);
    cyc(); #1;
    chk("late_resp:still_idle", 64'(rsp_valid), 64'd0);
    lookup_miss(27'h10, 16'd1, 44'h55, 1'b0, 3'd0, 0, 1'b0, "after_rst_miss");

    // Counter scenario: 2 misses and 3 hits after a fresh reset.
    rst = 1'b1;
    cyc(); rst = 1'b0;
    lookup_miss(27'h10, 16'd1, 44'h55, 1'b0, 3'd0, 0, 1'b0, "cnt_miss1");
    lookup_hit(27'h10, 16'd1, 44'h55, 3'd0, "cnt_hit1");
    lookup_hit(27'h10, 16'd1, 44'h55, 3'd0, "cnt_hit2");
    lookup_hit(27'h10, 16'd1, 44'h55, 3'd0, "cnt_hit3");
    lookup_miss(27'h20, 16'd1, 44'h66, 1'b0, 3'd1, 0, 1'b0, "cnt_miss2");
`ifdef TLB_PERF_CNT_EN
    chk("cnt:hit", 64'(hit_cnt), 64'd3);
    chk("cnt:miss", 64'(miss_cnt), 64'd2);
    rst = 1'b1;
    cyc(); rst = 1'b0; #1;
    chk("cnt:hit_reset", 64'(hit_cnt), 64'd0);
    chk("cnt:miss_reset", 64'(miss_cnt), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlb_miss_ctrl.md
TLB_MISS_CTRL -- requirements
Module: tlb_miss_ctrl

Interface
REQ-001 SHALL have parameters: ENTRIES, default 8, TLB entry count (power of 2, >=2); VPN_W, default 27, virtual page number width; PPN_W, default 44, physical page number width; ASID_W, default 16, address-space ID width.
REQ-002 SHALL have ports: clk_i  in  1  clock; rst_i  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: lu_valid_i  in  1  lookup request; lu_ready_o  out  1  request accepted; lu_vpn_i  in  VPN_W  lookup VPN; lu_asid_i  in  ASID_W  lookup ASID.
REQ-004 SHALL have ports: rsp_valid_o  out  1  translation done; rsp_ppn_o  out  PPN_W  result; rsp_error_o  out  1  walk fault.
REQ-005 SHALL have ports: ptw_req_valid_o  out  1; ptw_req_ready_i  in  1; ptw_req_vpn_o  out  VPN_W; ptw_resp_valid_i  in  1; ptw_resp_ppn_i  in  PPN_W; ptw_resp_error_i  in  1.
REQ-006 SHALL have ports: plru_hit_o  out  1  access-hit strobe to pseudoLRU; plru_idx_o  out  log2(ENTRIES)  accessed entry; plru_repl_idx_i  in  log2(ENTRIES)  victim from pseudoLRU; flush_i  in  1  invalidate all entries.

Function
REQ-007 SHALL implement FSM states IDLE, WALK_REQ, WALK_WAIT, FILL; lu_ready_o high only in IDLE with flush_i low.
REQ-008 SHALL register {vpn, asid} on lu_valid_i & lu_ready_o; next cycle, compare against all valid entries (match = valid & vpn eq & asid eq).
REQ-009 On hit SHALL assert rsp_valid_o for one cycle with matching PPN, rsp_error_o=0, plru_hit_o=1, plru_idx_o=hit index, remaining in IDLE; hit latency exactly 1 cycle after accept.
REQ-010 More than one matching entry SHALL resolve to the lowest index.
REQ-011 On miss SHALL go to WALK_REQ, driving ptw_req_valid_o=1 and ptw_req_vpn_o stable until ptw_req_ready_i; then WALK_WAIT.
REQ-012 In WALK_WAIT, on ptw_resp_valid_i SHALL capture ppn/error and go to FILL.
REQ-013 FILL victim SHALL be the lowest invalid entry if any exists, else plru_repl_idx_i sampled in FILL.
REQ-014 In FILL without error SHALL write {valid=1, vpn, asid, ppn} to victim, pulse rsp_valid_o, pulse plru_hit_o with plru_idx_o=victim, return to IDLE.
REQ-015 In FILL with error SHALL write no entry, pulse rsp_valid_o with rsp_error_o=1 and rsp_ppn_o=0, plru_hit_o=0, return to IDLE.
REQ-016 flush_i SHALL clear all valid bits next cycle; in IDLE it takes priority over lookups (no accept that cycle).
REQ-017 flush_i during WALK_REQ/WALK_WAIT SHALL not abort the walk; the FILL response is still returned but the entry SHALL NOT be written.
REQ-018 plru_hit_o, rsp_valid_o SHALL never assert in the same cycle as lu_ready_o-accepting cycle of a new request for a different lookup.

Reset
REQ-019 rst_i SHALL force state IDLE, all valid bits 0, rsp_valid_o=0, rsp_error_o=0, rsp_ppn_o=0, ptw_req_valid_o=0, plru_hit_o=0, plru_idx_o=0; lu_ready_o=1 the cycle after reset deasserts.
REQ-020 Reset mid-walk SHALL drop the walk; a late ptw_resp_valid_i in IDLE SHALL be ignored.

Configuration
REQ-021 Macro TLB_PERF_CNT_EN defined SHALL add outputs hit_cnt_o, miss_cnt_o (32 bits each, wrap at 2^32, reset 0, incremented on REQ-009 hit / REQ-011 miss); undefined, ports and counters SHALL be absent.

Structure
REQ-022 Package mmu_tlb_pkg SHALL hold tlb_entry_t (valid, vpn, asid, ppn) and the FSM state enum; parameters stay on the module.
REQ-023 Sub-module tlb_cam_match (combinational compare plus lowest-index encode, outputs hit and idx) SHALL be instantiated once.

Verification
REQ-024 Reset, lookup vpn=0x10 asid=1 -> miss, ptw_req_vpn_o=0x10; resp ppn=0x55 -> rsp_valid_o, ppn 0x55, written to entry 0, plru_idx_o=0.
REQ-025 Repeat lookup vpn=0x10 asid=1 -> rsp_valid_o one cycle after accept, ppn 0x55, plru_hit_o=1, no PTW request; same vpn asid=2 -> miss.
REQ-026 Fill all 8 entries, then miss with plru_repl_idx_i=5 -> entry 5 overwritten, others unchanged.
REQ-027 ptw_req_ready_i held low 4 cycles -> ptw_req_valid_o and ptw_req_vpn_o stable; resp error=1 -> rsp_error_o=1, no entry written.
REQ-028 flush_i during WALK_WAIT -> response returned, TLB empty afterward; next lookup of same vpn misses.
REQ-029 With TLB_PERF_CNT_EN: 3 hits, 2 misses -> hit_cnt_o=3, miss_cnt_o=2; rst_i clears both.
